// File: rtl/fp_div_sqrt_scheduler.sv
// fp_div_sqrt_scheduler: arbitrates FP issue lanes onto one iterative div/sqrt unit
// and tracks the reserved op through execute, flush and writeback.
module fp_div_sqrt_scheduler #(
    parameter int LANES = 2,
    parameter int ALPTR_W = 7,
    parameter int LAT_DIV = 16,
    parameter int LAT_SQRT = 24,
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1,
    localparam int MAXL = LAT_DIV > LAT_SQRT ? LAT_DIV : LAT_SQRT,
    localparam int CW = MAXL > 1 ? $clog2(MAXL) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [LANES-1:0]         req_valid,
    input  logic [LANES-1:0]         req_is_sqrt,
    input  logic [LANES*ALPTR_W-1:0] req_al_ptr,
    output logic [LANES-1:0]         grant,
    output logic                     available,
    input  logic [LANES-1:0]         rr_flushed,
    input  logic [LANES-1:0]         ex_start,
    input  logic                     flush_valid,
    input  logic                     flush_all,
    input  logic [ALPTR_W-1:0]       flush_head,
    input  logic [ALPTR_W-1:0]       flush_tail,
    output logic                     unit_start,
    output logic                     unit_abort,
    output logic                     unit_is_sqrt,
    output logic                     done,
    output logic [LW-1:0]            done_lane,
    output logic [ALPTR_W-1:0]       done_al_ptr,
    input  logic                     wb_ack
);
    typedef enum logic [1:0] {IDLE, RESERVED, EXEC, WAIT_WB} state_t;

    state_t             state, state_n;
    logic [LW-1:0]      owner, owner_n, rr, rr_n, gidx;
    logic               is_sqrt, is_sqrt_n, found, in_range, killed;
    logic [ALPTR_W-1:0] al_ptr, al_ptr_n;
    logic [CW-1:0]      cnt, cnt_n;

    assign in_range = flush_head <= flush_tail ? (flush_head <= al_ptr && al_ptr < flush_tail)
                                               : (al_ptr >= flush_head || al_ptr < flush_tail);
    assign killed = flush_valid && (flush_all || in_range);
    assign available = state == IDLE;
    assign unit_is_sqrt = is_sqrt && state != IDLE;
    assign done_lane = owner;
    assign done_al_ptr = al_ptr;

    always_comb begin
        state_n = state;
        owner_n = owner;
        is_sqrt_n = is_sqrt;
        al_ptr_n = al_ptr;
        cnt_n = cnt;
        rr_n = rr;
        grant = '0;
        unit_start = 1'b0;
        unit_abort = 1'b0;
        done = 1'b0;
        found = 1'b0;
        gidx = '0;
        // round-robin search starting at rr, wrapping past the last lane
        for (int i = 0; i < LANES; i++) begin
            if (!found && req_valid[(int'(rr) + i) % LANES]) begin
                found = 1'b1;
                gidx = LW'((int'(rr) + i) % LANES);
            end
        end
        case (state)
            IDLE: begin
                if (found && !stall && !flush_valid) begin
                    grant[gidx] = 1'b1;
                    state_n = RESERVED;
                    owner_n = gidx;
                    is_sqrt_n = req_is_sqrt[gidx];
                    al_ptr_n = req_al_ptr[int'(gidx)*ALPTR_W +: ALPTR_W];
                    rr_n = LW'((int'(gidx) + 1) % LANES);
                end
            end
            RESERVED: begin
                if (killed || rr_flushed[owner]) begin
                    state_n = IDLE;
                end else if (ex_start[owner] && !stall) begin
                    state_n = EXEC;
                    unit_start = 1'b1;
                    cnt_n = is_sqrt ? CW'(LAT_SQRT - 1) : CW'(LAT_DIV - 1);
                end
            end
            EXEC: begin
                unit_abort = killed;
                state_n = killed ? IDLE : (cnt == '0 ? WAIT_WB : EXEC);
                cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
            end
            default: begin
                unit_abort = killed;
                done = !killed;
                state_n = killed || (wb_ack && !stall) ? IDLE : WAIT_WB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            is_sqrt <= 1'b0;
            al_ptr <= '0;
            cnt <= '0;
            rr <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            is_sqrt <= is_sqrt_n;
            al_ptr <= al_ptr_n;
            cnt <= cnt_n;
            rr <= rr_n;
        end
    end
endmodule

// File: tb/tb_fp_div_sqrt_scheduler.sv
// tb_fp_div_sqrt_scheduler: directed and randomized checks of the div/sqrt scheduler
// against a lane/latency reference model.
module tb_fp_div_sqrt_scheduler;
    localparam int LAT_DIV = 16;
    localparam int LAT_SQRT = 24;

    logic        clk = 1'b0;
    logic        rst, stall, flush_valid, flush_all, wb_ack;
    logic [1:0]  req_valid, req_is_sqrt, rr_flushed, ex_start;
    logic [13:0] req_al_ptr;
    logic [6:0]  flush_head, flush_tail;
    logic [1:0]  grant;
    logic        available, unit_start, unit_abort, unit_is_sqrt, done;
    logic [0:0]  done_lane;
    logic [6:0]  done_al_ptr;

    int checks = 0;
    int errors = 0;
    int m_rr = 0;

    fp_div_sqrt_scheduler #(.LANES(2), .ALPTR_W(7), .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_is_sqrt(req_is_sqrt),
        .req_al_ptr(req_al_ptr), .grant(grant), .available(available), .rr_flushed(rr_flushed),
        .ex_start(ex_start), .flush_valid(flush_valid), .flush_all(flush_all),
        .flush_head(flush_head), .flush_tail(flush_tail), .unit_start(unit_start),
        .unit_abort(unit_abort), .unit_is_sqrt(unit_is_sqrt), .done(done), .done_lane(done_lane),
        .done_al_ptr(done_al_ptr), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; req_valid = 0; req_is_sqrt = 0; req_al_ptr = 0; rr_flushed = 0; ex_start = 0;
        flush_valid = 0; flush_all = 0; flush_head = 0; flush_tail = 0; wb_ack = 0;
    endtask

    task automatic reserve(input logic [1:0] mask, input logic [1:0] sq, input logic [13:0] ptrs,
                           output int lane);
        lane = -1;
        for (int i = 0; i < 2; i++)
            if (lane < 0 && mask[(m_rr + i) % 2]) lane = (m_rr + i) % 2;
        req_valid = mask; req_is_sqrt = sq; req_al_ptr = ptrs;
        #1;
        chk("grant", {30'd0, grant}, 32'(1) << lane);
        tick();
        req_valid = 0;
        m_rr = (lane + 1) % 2;
        chk("reserved_busy", {31'd0, available}, 0);
    endtask

    task automatic start_exec(input int lane);
        ex_start = 0;
        ex_start[lane] = 1'b1;
        #1;
        chk("unit_start", {31'd0, unit_start}, 1);
        tick();
        ex_start = 0;
        chk("start_pulse", {31'd0, unit_start}, 0);
    endtask

    task automatic do_op(input logic [1:0] mask, input logic [1:0] sq, input logic [13:0] ptrs,
                         input int gap);
        int l;
        int lat;
        reserve(mask, sq, ptrs, l);
        for (int i = 0; i < gap; i++) begin
            ex_start = 2'b00;
            ex_start[1 - l] = 1'b1;
            stall = 1'($urandom % 2);
            #1;
            chk("rsv_nostart", {31'd0, unit_start}, 0);
            tick();
        end
        stall = 0;
        chk("unit_is_sqrt", {31'd0, unit_is_sqrt}, {31'd0, sq[l]});
        start_exec(l);
        lat = sq[l] ? LAT_SQRT : LAT_DIV;
        for (int i = 1; i <= lat; i++) begin
            stall = 1'($urandom % 2);
            req_valid = 2'($urandom);
            #1;
            chk("exec_nodone", {31'd0, done}, 0);
            chk("exec_nogrant", {30'd0, grant}, 0);
            tick();
        end
        stall = 0; req_valid = 0;
        #1;
        chk("done", {31'd0, done}, 1);
        chk("done_lane", {31'd0, done_lane}, l);
        chk("done_al_ptr", {25'd0, done_al_ptr}, {25'd0, ptrs[l*7 +: 7]});
        wb_ack = 1;
        tick();
        wb_ack = 0;
        chk("released", {31'd0, available}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int n;
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_available", {31'd0, available}, 1);
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_start", {31'd0, unit_start}, 0);
        chk("rst_abort", {31'd0, unit_abort}, 0);

        // lane 0 div with immediate ex_start, then round-robin moves to lane 1
        do_op(2'b11, 2'b00, {7'd33, 7'd9}, 0);
        do_op(2'b11, 2'b11, {7'd44, 7'd10}, 1);

        // flush_valid blocks grant even when nothing is in range
        req_valid = 2'b11; flush_valid = 1; flush_head = 7'd4; flush_tail = 7'd4;
        #1;
        chk("flush_blocks_grant", {30'd0, grant}, 0);
        tick();
        flush_valid = 0; req_valid = 0;
        chk("flush_idle_stays", {31'd0, available}, 1);

        // rr_flushed and ex_start together: no start, back to IDLE
        reserve(2'b01, 2'b00, 14'd0, l);
        rr_flushed[l] = 1; ex_start[l] = 1;
        #1;
        chk("rrflush_nostart", {31'd0, unit_start}, 0);
        tick();
        rr_flushed = 0; ex_start = 0;
        chk("rrflush_idle", {31'd0, available}, 1);

        // killed in EXEC: plain range, then wrapped range
        reserve(2'b10, 2'b00, {7'd5, 7'd0}, l);
        start_exec(l);
        tick();
        flush_valid = 1; flush_head = 7'd3; flush_tail = 7'd8;
        #1;
        chk("abort_range", {31'd0, unit_abort}, 1);
        tick();
        flush_valid = 0;
        chk("abort_idle", {31'd0, available}, 1);
        chk("abort_pulse", {31'd0, unit_abort}, 0);

        reserve(2'b01, 2'b01, {7'd0, 7'd2}, l);
        start_exec(l);
        flush_valid = 1; flush_head = 7'd120; flush_tail = 7'd4;
        #1;
        chk("abort_wrap", {31'd0, unit_abort}, 1);
        tick();
        flush_valid = 0;
        chk("abort_wrap_idle", {31'd0, available}, 1);

        reserve(2'b10, 2'b00, {7'd50, 7'd0}, l);
        start_exec(l);
        flush_valid = 1; flush_head = 7'd120; flush_tail = 7'd4;
        #1;
        chk("wrap_outside", {31'd0, unit_abort}, 0);
        tick();
        flush_valid = 0;
        chk("wrap_outside_busy", {31'd0, available}, 0);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("wrap_outside_done", {31'd0, done}, 1);
        chk("wrap_outside_ptr", {25'd0, done_al_ptr}, 50);
        wb_ack = 1;
        tick();
        wb_ack = 0;

        // WAIT_WB held under stall for 10 cycles
        reserve(2'b01, 2'b00, {7'd0, 7'd77}, l);
        start_exec(l);
        for (int i = 0; i < LAT_DIV; i++) tick();
        stall = 1; req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hold_done", {31'd0, done}, 1);
            chk("hold_lane", {31'd0, done_lane}, l);
            chk("hold_ptr", {25'd0, done_al_ptr}, 77);
            chk("hold_nogrant", {30'd0, grant}, 0);
            tick();
        end
        wb_ack = 1;
        tick();
        chk("stall_blocks_ack", {31'd0, done}, 1);
        stall = 0;
        #1;
        chk("release_nogrant", {30'd0, grant}, 0);
        tick();
        wb_ack = 0; req_valid = 0;
        chk("release_idle", {31'd0, available}, 1);

        // reset during EXEC
        reserve(2'b01, 2'b01, 14'd3, l);
        start_exec(l);
        tick(); tick();
        rst = 1;
        #1;
        chk("rst_no_abort", {31'd0, unit_abort}, 0);
        tick();
        rst = 0;
        m_rr = 0;
        chk("rst_exec_idle", {31'd0, available}, 1);
        chk("rst_exec_nodone", {31'd0, done}, 0);

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            do_op(mask, 2'($urandom), 14'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_div_sqrt_scheduler.md
FP_DIV_SQRT_SCHEDULER -- requirements
Module: fp_div_sqrt_scheduler

Interface
REQ-001 Parameter LANES, default 2, number of FP issue lanes sharing one iterative div/sqrt unit.
REQ-002 Parameter ALPTR_W, default 7, active-list pointer width.
REQ-003 Parameter LAT_DIV, default 16, div execute cycles; LAT_SQRT, default 24, sqrt execute cycles; both >=1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  backend stall.
REQ-007 req_valid  in  LANES  issue-side request to reserve the unit, per lane.
REQ-008 req_is_sqrt  in  LANES  request is sqrt (else div).
REQ-009 req_al_ptr  in  LANES*ALPTR_W  active-list pointer per request.
REQ-010 grant  out  LANES  one-hot reservation grant, combinational.
REQ-011 available  out  1  unit free (state IDLE).
REQ-012 rr_flushed  in  LANES  reserved op flushed in register-read stage.
REQ-013 ex_start  in  LANES  reserved op entered execute with operands.
REQ-014 flush_valid, flush_all  in  1 each; flush_head, flush_tail  in  ALPTR_W each  selective flush range.
REQ-015 unit_start, unit_abort, unit_is_sqrt  out  1 each  datapath controls.
REQ-016 done  out  1; done_lane  out  clog2(LANES); done_al_ptr  out  ALPTR_W  result ready for writeback.
REQ-017 wb_ack  in  1  writeback accepted the result.

Function
REQ-018 States IDLE, RESERVED, EXEC, WAIT_WB; registers: owner lane, is_sqrt, al_ptr, countdown (clog2(max(LAT_DIV,LAT_SQRT)) bits), round-robin pointer rr.
REQ-019 killed = flush_valid && (flush_all || inRange(al_ptr)); inRange = head<=tail ? (head<=p && p<tail) : (p>=head || p<tail); head==tail with !flush_all kills nothing.
REQ-020 grant: only in IDLE, !stall, !flush_valid; highest-priority requesting lane searching from rr upward with wrap; at most one bit set.
REQ-021 On grant of lane k: -> RESERVED, latch owner=k, is_sqrt, al_ptr; rr <= (k+1) mod LANES.
REQ-022 RESERVED priority: killed -> IDLE; else rr_flushed[owner] -> IDLE; else ex_start[owner] && !stall -> EXEC; else hold. Non-owner rr_flushed/ex_start ignored.
REQ-023 unit_start = RESERVED && ex_start[owner] && !stall && !killed && !rr_flushed[owner] (same cycle as transition); countdown loaded with LAT-1 of latched op type.
REQ-024 EXEC: countdown decrements each cycle regardless of stall; at countdown==0 -> WAIT_WB; EXEC lasts exactly LAT cycles; done first high LAT+1 cycles after unit_start cycle.
REQ-025 EXEC or WAIT_WB with killed: -> IDLE next edge; unit_abort high that cycle (one-cycle pulse); done forced low in that cycle.
REQ-026 WAIT_WB: done=1, done_lane=owner, done_al_ptr=al_ptr; wb_ack && !killed -> IDLE; stall holds state; wb_ack outside WAIT_WB ignored.
REQ-027 unit_is_sqrt = latched is_sqrt, valid RESERVED..WAIT_WB.
REQ-028 available = (state==IDLE); IDLE entered on release is grantable the following cycle (no same-cycle release-and-grant).

Reset
REQ-029 rst forces IDLE, rr=0, countdown=0, owner/al_ptr/is_sqrt=0; outputs grant=0, unit_start=0, unit_abort=0, done=0, available=1 in the cycle after rst.
REQ-030 rst mid-operation aborts without a unit_abort pulse; rst has priority over all inputs.

Verification
REQ-031 Div on lane 0, ex_start next cycle, LAT_DIV=16 -> unit_start 1 cycle, done high 17 cycles later with done_lane=0, wb_ack -> available next cycle.
REQ-032 req_valid=2'b11 in IDLE, rr=0 -> grant=01; after release, both again -> grant=10 (round-robin).
REQ-033 RESERVED, rr_flushed[owner] and ex_start[owner] same cycle -> no unit_start, IDLE next cycle.
REQ-034 EXEC al_ptr=5, flush head=3 tail=8 -> unit_abort pulse, IDLE; repeat with head=120 tail=4 (wrap), al_ptr=2 -> abort; al_ptr=50 -> unaffected.
REQ-035 WAIT_WB with stall=1 and wb_ack=0 for 10 cycles -> done held with stable lane/ptr; grant stays 0 despite requests.
REQ-036 rst asserted in EXEC -> IDLE, available=1, no unit_abort, no done.
